count_enable_gen: RTL

Upstream stage for the 4-bit event counter. It turns a raw, asynchronous, bouncing push-button/event line into clean single-cycle enable pulses that drive the counter's enable input. The block synchronises the input, debounces it in both directions, and emits one pulse per press. Optional auto-repeat emits further pulses while the key is held. It also keeps a running count of emitted pulses for debug and bench cross-checking.

---
 rtl/count_enable_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/count_enable_gen.sv
// Synchronises, debounces and edge-detects a raw key line into single-cycle enable pulses,
// with optional auto-repeat while held and a free-running count of emitted pulses.
module count_enable_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int REPEAT_CYCLES   = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_in,
    input  logic             repeat_en,
    output logic             enable_out,
    output logic             key_state,
    output logic [CNT_W-1:0] pulse_count
);

    localparam int MAX_A  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int TW     = $clog2(MAX_C + 1);

    localparam logic [TW-1:0]    T_ONE    = TW'(1);
    localparam logic [TW-1:0]    DEB_LAST = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]    HLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    REP_LAST = TW'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, PRESS, HELD, REPEAT, RELEASE} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          s1, key_s;
    logic          pulse_n;
    logic          key_state_n;

    always_comb begin
        state_n = state;
        timer_n = timer;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_n = HELD;
                        timer_n = '0;
                        pulse_n = 1'b1;
                    end else begin
                        state_n = PRESS;
                        timer_n = T_ONE;
                    end
                end
            end
            PRESS: begin
                if (!key_s) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (timer == DEB_LAST) begin
                    state_n = HELD;
                    timer_n = '0;
                    pulse_n = 1'b1;
                end else begin
                    timer_n = timer + T_ONE;
                end
            end
            HELD, REPEAT: begin
                // A low sample wins over any pending repeat pulse on the same edge.
                if (!key_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_n = IDLE;
                        timer_n = '0;
                    end else begin
                        state_n = RELEASE;
                        timer_n = T_ONE;
                    end
                end else if (!repeat_en) begin
                    state_n = HELD;
                    timer_n = '0;
                end else if (state == HELD && timer == HLD_LAST) begin
                    state_n = REPEAT;
                    timer_n = '0;
                    pulse_n = 1'b1;
                end else if (state == REPEAT && timer == REP_LAST) begin
                    timer_n = '0;
                    pulse_n = 1'b1;
                end else begin
                    timer_n = timer + T_ONE;
                end
            end
            RELEASE: begin
                if (key_s) begin
                    state_n = HELD;
                    timer_n = '0;
                end else if (timer == DEB_LAST) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + T_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    assign key_state_n = (state_n == HELD) || (state_n == REPEAT) || (state_n == RELEASE);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1          <= 1'b0;
            key_s       <= 1'b0;
            state       <= IDLE;
            timer       <= '0;
            enable_out  <= 1'b0;
            key_state   <= 1'b0;
            pulse_count <= '0;
        end else begin
            s1          <= key_in;
            key_s       <= s1;
            state       <= state_n;
            timer       <= timer_n;
            enable_out  <= pulse_n;
            key_state   <= key_state_n;
            if (pulse_n) begin
                pulse_count <= pulse_count + C_ONE;
            end
        end
    end

endmodule
